gf180mcu_osu_sc_12t_tbus_ctrl: RTL

- Enable controller for a shared tristate bus built from the library's tristate-inverter cells. It feeds their EN/EN_BAR inputs.
- Arbitrates N requesters round-robin and drives one-hot complementary enable pairs.
- Inserts a break-before-make turnaround gap on every owner change, so two drivers never fight.
- Sits directly upstream of the tinv driver column; one EN/EN_BAR pair per bus-driver row.

---
 rtl/gf180mcu_osu_sc_tbus_pkg.sv | 21 ++
 rtl/gf180mcu_osu_sc_12t_rr_pick.sv | 34 +++
 rtl/gf180mcu_osu_sc_12t_tbus_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gf180mcu_osu_sc_tbus_pkg.sv
// Shared types and helpers for the tristate-bus enable controller.
// Turnaround counter width and one-hot decode used by the arbiter.
package gf180mcu_osu_sc_tbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } tbus_state_e;

    localparam int TURN_W = 4;

    function automatic logic [15:0] onehot(input int unsigned idx, input int unsigned n);
        logic [15:0] r;
        r = '0;
        if (idx < n && idx < 16)
            r = 16'd1 << idx;
        return r;
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from N-1 back to 0.
module gf180mcu_osu_sc_12t_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    logic [2*N-1:0] rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;

    always_comb begin
        rot   = {req, req} >> ptr;
        off   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = PW'(i);
                valid = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW + 1)'(N))
            sum = sum - (PW + 1)'(N);
        idx = sum[PW-1:0];
    end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_tbus_ctrl.sv
// Break-before-make enable controller for a shared tinv bus: round-robin
// ownership, one-hot EN with complementary EN_BAR, all-off gap between owners.
//
//   state | meaning
//   IDLE  | bus undriven, nobody requesting
//   OWN   | one row drives the bus (EN[owner]=1)
//   TURN  | all rows off, turnaround countdown before the next owner
module gf180mcu_osu_sc_12t_tbus_ctrl
    import gf180mcu_osu_sc_tbus_pkg::*;
#(
    parameter int N        = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GNT,
    output logic [N-1:0]         EN,
    output logic [N-1:0]         EN_BAR,
    output logic                 BUSY,
    output logic [$clog2(N)-1:0] OWNER
);

    localparam int PW     = $clog2(N);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);

    tbus_state_e       state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic              busy_q, busy_d;

    logic [PW-1:0]     pick_idx;
    logic              pick_vld;
    logic [15:0]       pick_oh;
    logic [N-1:0]      others;
    logic              release_own;

    gf180mcu_osu_sc_12t_rr_pick #(.N(N)) u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign pick_oh = onehot(32'(pick_idx), N);
    assign others  = REQ & ~gnt_q;

    // Forced release only matters when someone else is actually waiting.
    assign release_own = !REQ[owner_q] ||
                         ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (|others));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    hold_d  = '0;
                    gnt_d   = pick_oh[N-1:0];
                    busy_d  = 1'b1;
                end
            end
            OWN: begin
                if (release_own) begin
                    state_d = TURN;
                    turn_d  = TURN_LOAD;
                    ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q == '0) begin
                    if (pick_vld) begin
                        state_d = OWN;
                        owner_d = pick_idx;
                        hold_d  = '0;
                        gnt_d   = pick_oh[N-1:0];
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign GNT    = gnt_q;
    assign EN     = gnt_q;
    assign EN_BAR = ~gnt_q;
    assign BUSY   = busy_q;
    assign OWNER  = owner_q;

endmodule
